fxp_acc_ctrl: RTL and testbench

Sequencing controller for the adaptive-Q fixed-point adder in the matrix-multiply datapath. It accepts a stream of LEN signed terms over a valid/ready handshake, each tagged with its own fractional width. It aligns each term to the running accumulator format and adds it, widening the integer field on overflow. After the last term it renormalises the result back toward maximum fractional precision and presents the sum with its Q-format on a held output handshake.

---
 rtl/fxp_acc_ctrl_pkg.sv | 16 +
 rtl/fxp_acc_ctrl_if.sv | 34 +++
 rtl/fxp_qalign_add.sv | 63 ++++++
 rtl/fxp_acc_ctrl.sv | 117 +++++++++++
 tb/tb_fxp_acc_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fxp_acc_ctrl_pkg.sv
// Shared configuration for the adaptive-Q accumulator controller:
// default sizes, Q-field width and FSM state encoding.
package fxp_acc_ctrl_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_LEN_W     = 8;
  localparam int QW            = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    NORM  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fxp_acc_ctrl_if.sv
// Term-stream and result handshake bundle for fxp_acc_ctrl; the
// master side feeds jobs and terms, the slave side is the controller.
interface fxp_acc_ctrl_if
  import fxp_acc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LEN_W     = DEF_LEN_W
);

  logic                 start;
  logic [LEN_W-1:0]     len;
  logic [WORD_SIZE-1:0] term;
  logic [QW-1:0]        term_qf;
  logic                 term_valid;
  logic                 term_ready;
  logic [WORD_SIZE-1:0] res;
  logic [QW-1:0]        res_qi;
  logic [QW-1:0]        res_qf;
  logic                 res_valid;
  logic                 res_ready;
  logic                 sat;
  logic                 busy;

  modport master (
    output start, len, term, term_qf, term_valid, res_ready,
    input  term_ready, res, res_qi, res_qf, res_valid, sat, busy
  );

  modport slave (
    input  start, len, term, term_qf, term_valid, res_ready,
    output term_ready, res, res_qi, res_qf, res_valid, sat, busy
  );

endinterface

// File: rtl/fxp_qalign_add.sv
// Combinational aligned add of two Q-formatted words: aligns to the
// coarser fraction, widens the integer field on overflow, else saturates.
module fxp_qalign_add
  import fxp_acc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic signed [WORD_SIZE-1:0] a,
  input  logic        [QW-1:0]        qf_a,
  input  logic signed [WORD_SIZE-1:0] b,
  input  logic        [QW-1:0]        qf_b,
  output logic signed [WORD_SIZE-1:0] sum,
  output logic        [QW-1:0]        qf_out,
  output logic                        sat_hit
);

  localparam logic [QW-1:0] MAX_SH = QW'(WORD_SIZE - 1);

  logic        [QW-1:0]        diff;
  logic        [QW-1:0]        sh;
  logic        [QW-1:0]        qf_base;
  logic signed [WORD_SIZE-1:0] a_al;
  logic signed [WORD_SIZE-1:0] b_al;
  logic signed [WORD_SIZE-1:0] raw;
  logic                        ovf;

  // The finer operand loses its extra fraction bits by truncating shift.
  always_comb begin
    a_al    = a;
    b_al    = b;
    sum     = '0;
    qf_out  = '0;
    sat_hit = 1'b0;
    if (qf_a > qf_b) begin
      diff    = qf_a - qf_b;
      qf_base = qf_b;
    end else begin
      diff    = qf_b - qf_a;
      qf_base = qf_a;
    end
    sh = (diff > MAX_SH) ? MAX_SH : diff;
    if (qf_a > qf_b) a_al = a >>> sh;
    else             b_al = b >>> sh;

    raw = a_al + b_al;
    ovf = (a_al[WORD_SIZE-1] == b_al[WORD_SIZE-1]) &&
          (raw[WORD_SIZE-1] != a_al[WORD_SIZE-1]);

    sum    = raw;
    qf_out = qf_base;
    if (ovf) begin
      if (qf_base != '0) begin
        sum    = (a_al >>> 1) + (b_al >>> 1);
        qf_out = qf_base - 1'b1;
      end else begin
        sat_hit = 1'b1;
        sum     = a_al[WORD_SIZE-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                                    : {1'b0, {(WORD_SIZE-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/fxp_acc_ctrl.sv
// Sequencing controller for the adaptive-Q accumulator: accepts LEN terms,
// accumulates them with format widening, renormalises and holds the result.
module fxp_acc_ctrl
  import fxp_acc_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  fxp_acc_ctrl_if.slave bus
);

  localparam logic [QW-1:0] QF_MAX = QW'(WORD_SIZE - 1);

  state_t                      state;
  state_t                      next_state;
  logic signed [WORD_SIZE-1:0] acc;
  logic        [QW-1:0]        acc_qf;
  logic        [LEN_W-1:0]     count;
  logic                        first;
  logic                        sat_r;

  logic signed [WORD_SIZE-1:0] sum;
  logic        [QW-1:0]        qf_out;
  logic                        sat_hit;
  logic                        accept;
  logic                        norm_shift;

  fxp_qalign_add #(.WORD_SIZE(WORD_SIZE)) u_qalign_add (
    .a       (acc),
    .qf_a    (acc_qf),
    .b       (bus.term),
    .qf_b    (bus.term_qf),
    .sum     (sum),
    .qf_out  (qf_out),
    .sat_hit (sat_hit)
  );

  assign accept     = bus.term_valid && bus.term_ready;
  // A redundant sign bit can be traded for one more fraction bit while QI > 1.
  assign norm_shift = (acc[WORD_SIZE-1] == acc[WORD_SIZE-2]) && (acc_qf < QF_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && (count == LEN_W'(1))) next_state = NORM;
      NORM:    if (!norm_shift) next_state = DONE;
      DONE:    if (bus.res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.term_ready = (state == ACCUM);
    bus.res_valid  = (state == DONE);
    bus.busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      acc_qf <= QF_MAX;
      count  <= '0;
      first  <= 1'b0;
      sat_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sat_r <= 1'b0;
            count <= bus.len;
            first <= 1'b1;
            if (bus.len == '0) begin
              acc    <= '0;
              acc_qf <= QF_MAX;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            count <= count - 1'b1;
            first <= 1'b0;
            if (first) begin
              acc    <= bus.term;
              acc_qf <= bus.term_qf;
            end else begin
              acc    <= sum;
              acc_qf <= qf_out;
              if (sat_hit) sat_r <= 1'b1;
            end
          end
        end
        NORM: begin
          if (norm_shift) begin
            acc    <= acc <<< 1;
            acc_qf <= acc_qf + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // QI is derived from QF so the two always sum to WORD_SIZE (16 wraps to 0).
  assign bus.res    = acc;
  assign bus.res_qf = acc_qf;
  assign bus.res_qi = QW'(WORD_SIZE) - acc_qf;
  assign bus.sat    = sat_r;

endmodule

// File: tb/tb_fxp_acc_ctrl.sv
// Directed scoreboard bench for fxp_acc_ctrl: expected results are queued
// when a job is issued and compared when res_valid appears.
module tb_fxp_acc_ctrl;
  import fxp_acc_ctrl_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   qi;
    logic [3:0]   qf;
    logic         sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   lat;
  int   base_cnt;
  exp_t sb[$];

  always #5 clk = ~clk;

  fxp_acc_ctrl_if #(.WORD_SIZE(W), .LEN_W(8)) bus ();

  fxp_acc_ctrl #(.WORD_SIZE(W), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (rst_n && bus.term_valid && bus.term_ready) accepted <= accepted + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic startJob(input logic [7:0] l);
    bus.len   = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] t, input logic [3:0] q, input int gap);
    bus.term_valid = 1'b0;
    repeat (gap) tick();
    bus.term       = t;
    bus.term_qf    = q;
    bus.term_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.term_ready; i++) tick();
    tick();
    bus.term_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, output int cycles);
    exp_t e;
    cycles = 0;
    while (!bus.res_valid && cycles < 64) begin
      tick();
      cycles++;
    end
    checkOutput({tag, ".valid"}, 32'(bus.res_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, ".res"}, 32'(bus.res),    32'(e.res));
      checkOutput({tag, ".qi"},  32'(bus.res_qi), 32'(e.qi));
      checkOutput({tag, ".qf"},  32'(bus.res_qf), 32'(e.qf));
      checkOutput({tag, ".sat"}, 32'(bus.sat),    32'(e.sat));
    end
  endtask

  task automatic acceptResult(input string tag, input logic with_start);
    bus.res_ready = 1'b1;
    bus.start     = with_start;
    bus.len       = 8'd2;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    checkOutput({tag, ".idle_busy"},  32'(bus.busy),      32'd0);
    checkOutput({tag, ".idle_valid"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.term       = '0;
    bus.term_qf    = '0;
    bus.term_valid = 1'b0;
    bus.res_ready  = 1'b0;
    rst_n          = 1'b0;
    repeat (2) tick();
    checkOutput("rst.res",       32'(bus.res),        32'h0);
    checkOutput("rst.qi",        32'(bus.res_qi),     32'd1);
    checkOutput("rst.qf",        32'(bus.res_qf),     32'd15);
    checkOutput("rst.res_valid", 32'(bus.res_valid),  32'd0);
    checkOutput("rst.sat",       32'(bus.sat),        32'd0);
    checkOutput("rst.busy",      32'(bus.busy),       32'd0);
    checkOutput("rst.ready",     32'(bus.term_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Overflow widening: 1.0 = 0.5 + 0.5 needs an extra integer bit.
    sb.push_back(exp_t'{16'h4000, 4'd2, 4'd14, 1'b0});
    startJob(8'd2);
    checkOutput("widen.term_ready", 32'(bus.term_ready), 32'd1);
    checkOutput("widen.busy",       32'(bus.busy),       32'd1);
    applyStimulus(16'h4000, 4'd15, 0);
    applyStimulus(16'h4000, 4'd15, 0);
    waitResult("widen", lat);
    checkOutput("widen.latency", 32'(lat), 32'd1);
    acceptResult("widen", 1'b0);

    sb.push_back(exp_t'{16'h2000, 4'd1, 4'd15, 1'b0});
    startJob(8'd1);
    applyStimulus(16'h0400, 4'd12, 0);
    waitResult("norm", lat);
    checkOutput("norm.latency", 32'(lat), 32'd4);
    acceptResult("norm", 1'b0);

    sb.push_back(exp_t'{16'h6000, 4'd1, 4'd15, 1'b0});
    startJob(8'd2);
    applyStimulus(16'h2000, 4'd15, 0);
    applyStimulus(16'h2000, 4'd14, 0);
    waitResult("align", lat);
    checkOutput("align.latency", 32'(lat), 32'd2);
    acceptResult("align", 1'b0);

    sb.push_back(exp_t'{16'h7FFF, 4'd0, 4'd0, 1'b1});
    startJob(8'd2);
    applyStimulus(16'h7FFF, 4'd0, 0);
    applyStimulus(16'h0001, 4'd0, 0);
    waitResult("sat", lat);
    acceptResult("sat", 1'b0);

    // Gapped terms, held result, stray start and stray term_valid in DONE.
    base_cnt = accepted;
    sb.push_back(exp_t'{16'h7000, 4'd2, 4'd14, 1'b0});
    startJob(8'd3);
    applyStimulus(16'h1000, 4'd12, 2);
    applyStimulus(16'h0800, 4'd12, 1);
    applyStimulus(16'h0400, 4'd12, 3);
    waitResult("hs", lat);
    checkOutput("hs.latency", 32'(lat), 32'd3);
    checkOutput("hs.consumed", 32'(accepted - base_cnt), 32'd3);
    bus.term_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      bus.len   = 8'd2;
      tick();
      bus.start = 1'b0;
      checkOutput("hs.hold_res",   32'(bus.res),       32'h7000);
      checkOutput("hs.hold_qi",    32'(bus.res_qi),    32'd2);
      checkOutput("hs.hold_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.term_valid = 1'b0;
    checkOutput("hs.consumed_after", 32'(accepted - base_cnt), 32'd3);
    acceptResult("hs", 1'b1);
    tick();
    checkOutput("hs.still_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of a job, then an empty job.
    startJob(8'd3);
    applyStimulus(16'h1234, 4'd8, 0);
    checkOutput("mid.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid.busy",      32'(bus.busy),      32'd0);
    checkOutput("mid.res",       32'(bus.res),       32'h0);
    checkOutput("mid.qi",        32'(bus.res_qi),    32'd1);
    checkOutput("mid.qf",        32'(bus.res_qf),    32'd15);
    checkOutput("mid.res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("mid.sat",       32'(bus.sat),       32'd0);
    sb.push_back(exp_t'{16'h0000, 4'd1, 4'd15, 1'b0});
    startJob(8'd0);
    waitResult("len0", lat);
    checkOutput("len0.latency", 32'(lat), 32'd0);
    acceptResult("len0", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
